// File: rtl/btn_event_ctrl_pkg.sv
// Shared definitions for the button event controller.
//   CLK_HZ        : sys_clk frequency (27 MHz board oscillator)
//   ms_to_cycles  : converts a millisecond interval to sys_clk cycles
//   btn_state_e   : press-classification FSM encoding
package btn_event_ctrl_pkg;

  localparam int unsigned CLK_HZ = 27_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser, polarity normalisation and debouncer for a raw
// button pin.
// Ports:
//   sys_clk   in  system clock
//   sys_rst   in  synchronous reset, active-high
//   btn_in    in  raw asynchronous button pin
//   btn_level out debounced level, 1 = pressed (registered)
//   rise      out strobe: btn_level goes 0->1 at the next edge
//   fall      out strobe: btn_level goes 1->0 at the next edge
// rise/fall are look-ahead strobes, so a consumer that registers its reaction
// to them changes in the same cycle as btn_level.
module btn_sync_debounce #(
  parameter int unsigned DEB_CYCLES = 270_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic btn_in,
  output logic btn_level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  // Raw pin level while the button is released.
  localparam logic RAW_RELEASED = ACTIVE_LOW;

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          norm;
  logic          differs;
  logic          accept;

  assign norm    = ACTIVE_LOW ? ~sync_q : sync_q;
  assign differs = (norm != level_q);
  assign accept  = differs && (cnt_q == CW'(DEB_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (differs) begin
      if (accept) begin
        level_d = norm;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q  <= RAW_RELEASED;
      sync_q  <= RAW_RELEASED;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_in;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign rise      = accept && norm;
  assign fall      = accept && !norm;

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: turns the raw user button into debounced level,
// press/short/long single-cycle events, and keeps the chaser's speed-mode
// index and rotate direction.
// Ports:
//   sys_clk      in  system clock, 27 MHz
//   sys_rst      in  synchronous reset, active-high
//   btn_in       in  raw asynchronous button pin
//   btn_level    out debounced level, 1 = pressed
//   press_pulse  out 1-cycle pulse on accepted press
//   short_pulse  out 1-cycle pulse on release before the long threshold
//   long_pulse   out 1-cycle pulse when the hold reaches LONG_CYCLES
//   mode         out speed-mode index, wraps NUM_MODES-1 -> 0 on short press
//   dir          out rotate direction (0 = left, 1 = right), toggles on long press
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | button released, waiting for a debounced press
// ST_PRESSED | press accepted, counting hold time toward long threshold
// ST_LONG    | long press already reported, waiting silently for release
module btn_event_ctrl
  import btn_event_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = ms_to_cycles(10),
  parameter int unsigned LONG_CYCLES = ms_to_cycles(1000),
  parameter int unsigned NUM_MODES   = 4,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         btn_in,
  output logic                         btn_level,
  output logic                         press_pulse,
  output logic                         short_pulse,
  output logic                         long_pulse,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         dir
);

  localparam int unsigned MW = $clog2(NUM_MODES);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  logic deb_rise, deb_fall;

  btn_sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_sync_debounce (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .rise      (deb_rise),
    .fall      (deb_fall)
  );

  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [MW-1:0] mode_q, mode_d;
  logic          dir_q, dir_d;
  logic          press_q, press_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic [HW-1:0] hold_inc;

  // Saturating so a very long hold cannot wrap back to the threshold.
  assign hold_inc = (hold_q == HW'(LONG_CYCLES)) ? hold_q : hold_q + HW'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (deb_rise) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        hold_d = hold_inc;
        // Release is checked first so a release coinciding with the
        // threshold is classified as short.
        if (deb_fall) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
          mode_d  = (mode_q == MW'(NUM_MODES - 1)) ? '0 : mode_q + MW'(1);
        end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
          dir_d   = ~dir_q;
        end
      end
      ST_LONG: begin
        hold_d = hold_inc;
        if (deb_fall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign press_pulse = press_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign mode        = mode_q;
  assign dir         = dir_q;

endmodule
